// File: rtl/uart_rx_channel.sv
// uart_rx_channel: 8-N-1 UART receiver with footer-terminated packet deframer and 1-entry valid/ready output.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   fpga_uart_rx     - async serial line, idle high
//   rx_data_out      - payload byte
//   rx_valid_out     - rx_data_out/rx_last_out valid
//   rx_last_out      - final payload byte of the packet
//   rx_ready_in      - consumer accepts the beat when high with rx_valid_out
//   rx_frame_err     - one-cycle pulse on a bad stop bit
//   rx_overflow      - sticky, set when a payload byte is dropped
module uart_rx_channel #(
  parameter int CLKS_PER_BIT = 1736,
  parameter logic [31:0] FOOTER_WORD = 32'hFFFFFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fpga_uart_rx,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  output logic       rx_last_out,
  input  logic       rx_ready_in,
  output logic       rx_frame_err,
  output logic       rx_overflow
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic byte_stb, ferr;
  logic [7:0] win_q [0:4];
  logic [7:0] win_d [0:4];
  logic [7:0] ext [0:4];
  logic [2:0] wcnt_q, wcnt_d, n;
  logic [31:0] tail;
  logic match, emit, accept, load;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, ovf_q, ovf_d, ferr_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    byte_stb = 1'b0;
    ferr = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        state_d = s2_q ? R_IDLE : R_START;
      end
      R_START: if (cnt_q == HALF) begin
        // Mid start bit: a line that has gone high again was only a glitch.
        cnt_d = '0;
        bit_d = 3'd0;
        state_d = s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d = {s2_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? R_STOP : R_DATA;
      end
      R_STOP: if (cnt_q == FULL) begin
        // Leave at mid stop bit so the next start edge is never missed.
        cnt_d = '0;
        state_d = R_IDLE;
        byte_stb = s2_q;
        ferr = ~s2_q;
      end
    endcase
  end
  // The window never holds more than four bytes between strobes: a fifth
  // arrival either completes a footer (oldest byte is last) or pushes the
  // oldest byte out as ordinary payload.
  always_comb begin
    for (int i = 0; i < 5; i++)
      ext[i] = (3'(i) < wcnt_q) ? win_q[i] : (3'(i) == wcnt_q ? sh_q : 8'h00);
    n = wcnt_q + 3'd1;
    tail = (n == 3'd5) ? {ext[4], ext[3], ext[2], ext[1]} : {ext[3], ext[2], ext[1], ext[0]};
    match = (n >= 3'd4) && (tail == FOOTER_WORD);
    emit = byte_stb && (n == 3'd5);
    win_d = win_q;
    wcnt_d = wcnt_q;
    if (ferr) wcnt_d = 3'd0;
    else if (byte_stb) begin
      if (match) wcnt_d = 3'd0;
      else if (n == 3'd5) begin
        for (int i = 0; i < 4; i++) win_d[i] = ext[i+1];
        win_d[4] = 8'h00;
        wcnt_d = 3'd4;
      end else begin
        win_d = ext;
        wcnt_d = n;
      end
    end
  end
  always_comb begin
    accept = valid_q & rx_ready_in;
    load = emit & (~valid_q | accept);
    valid_d = load | (valid_q & ~accept);
    data_d = load ? ext[0] : data_q;
    last_d = load ? match : last_q;
    ovf_d = ovf_q | (emit & ~load);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      state_q <= R_IDLE;
      cnt_q <= '0;
      bit_q <= 3'd0;
      sh_q <= 8'h00;
      for (int i = 0; i < 5; i++) win_q[i] <= 8'h00;
      wcnt_q <= 3'd0;
      data_q <= 8'h00;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      ovf_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      s1_q <= fpga_uart_rx;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      win_q <= win_d;
      wcnt_q <= wcnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
      ferr_q <= ferr;
    end
  end
  assign rx_data_out = data_q;
  assign rx_valid_out = valid_q;
  assign rx_last_out = last_q;
  assign rx_frame_err = ferr_q;
  assign rx_overflow = ovf_q;
endmodule

// File: doc/uart_rx_channel.md
UART_RX_CHANNEL -- requirements
Module: uart_rx_channel

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1736, meaning clk cycles per UART bit (200 MHz / 115200).
REQ-002 The block SHALL have parameter FOOTER_WORD, default 32'hFFFFFFFF, meaning the 4-byte packet terminator; bytes are compared LSB byte first.
REQ-003 Port clk: input, 1 bit, single clock for all logic.
REQ-004 Port rst_n: input, 1 bit, synchronous, active-low reset.
REQ-005 Port fpga_uart_rx: input, 1 bit, asynchronous serial line, 8-N-1, idle high.
REQ-006 Port rx_data_out: output, 8 bits, payload byte.
REQ-007 Port rx_valid_out: output, 1 bit, rx_data_out/rx_last_out valid.
REQ-008 Port rx_last_out: output, 1 bit, final payload byte of the packet.
REQ-009 Port rx_ready_in: input, 1 bit, consumer accepts the beat when high with rx_valid_out.
REQ-010 Port rx_frame_err: output, 1 bit, one-cycle pulse on a bad stop bit.
REQ-011 Port rx_overflow: output, 1 bit, sticky; set when a payload byte is dropped.

Function
REQ-012 fpga_uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Receiver FSM states SHALL be R_IDLE, R_START, R_DATA, R_STOP.
REQ-014 R_IDLE -> R_START on a synchronized low level.
REQ-015 In R_START, at count CLKS_PER_BIT/2-1 (integer division): if the line is still low, go to R_DATA with counter 0; else return to R_IDLE (glitch rejected).
REQ-016 R_DATA SHALL sample 8 bits, LSB first, each at CLKS_PER_BIT cycles after the previous sample.
REQ-017 R_STOP SHALL sample once at CLKS_PER_BIT after bit 7; a high sample produces a one-cycle byte strobe; a low sample pulses rx_frame_err instead.
REQ-018 After either R_STOP outcome, the receiver SHALL return to R_IDLE on the next cycle without waiting for the end of the stop bit.
REQ-019 The deframer SHALL keep a 5-entry byte window W[0..4] plus an occupancy count 0..5; W[0] is the oldest entry.
REQ-020 On each byte strobe, the byte SHALL be appended to the window.
REQ-021 On a byte strobe, if the four newest bytes (including the new one) equal FOOTER_WORD bytes 0,1,2,3 in arrival order: the byte before them (if present) SHALL be emitted with last=1; the window SHALL then be cleared to count 0.
REQ-022 If REQ-021 matches with no preceding byte (count was 3), the window SHALL be cleared and nothing emitted (empty packet dropped).
REQ-023 On a byte strobe where the window would exceed 5 entries, W[0] SHALL be emitted with last=0 and the window shifted.
REQ-024 Terminator matching SHALL be first-match: four consecutive footer bytes always terminate, even when the sender intended them as payload.
REQ-025 An emitted byte SHALL load a 1-entry output register, and rx_valid_out SHALL assert on the cycle after the byte strobe.
REQ-026 The output register SHALL hold rx_data_out and rx_last_out stable while rx_valid_out=1 and rx_ready_in=0.
REQ-027 The output register SHALL clear on rx_valid_out & rx_ready_in, unless it is reloaded on the same cycle, in which case valid stays high with the new data.
REQ-028 If the output register is occupied and not being accepted when an emit occurs, the new byte SHALL be dropped and rx_overflow set (sticky until reset); window update proceeds normally.
REQ-029 A frame error SHALL clear the window (count 0), discarding the partial packet; the output register SHALL be unaffected.
REQ-030 The byte strobe and a consumer handshake in the same cycle SHALL both take effect.

Reset
REQ-031 While rst_n=0 at a clk edge, the following SHALL hold: FSM=R_IDLE, counters=0, window count=0, rx_valid_out=0, rx_last_out=0, rx_data_out=8'h00, rx_frame_err=0, rx_overflow=0, synchronizer flops=1.
REQ-032 Reset asserted mid-byte SHALL abandon that byte; after release, the receiver SHALL resynchronize on the next falling edge.

Verification
REQ-033 Sending A1 B2 C3 FF FF FF FF with rx_ready_in=1 SHALL produce beats A1/last0, B2/last0, C3/last1, and no more beats.
REQ-034 Sending 11 FF FF FF 22 FF FF FF FF SHALL produce beats 11, FF, FF, FF, 22(last1).
REQ-035 Sending FF FF FF FF alone SHALL produce no beat and leave the window count at 0.
REQ-036 With rx_ready_in=0, sending 01..07 followed by the footer SHALL hold beat 01 stable, drop the later emits, and set rx_overflow=1.
REQ-037 Sending a byte with stop bit=0 after 55 66 SHALL pulse rx_frame_err for 1 cycle; a subsequent 77 FF FF FF FF SHALL yield only 77(last1).
REQ-038 Pulsing rst_n low during bit 3 of a byte SHALL clear all outputs; the next full packet SHALL be received correctly.
